// File: rtl/sprite_cmd_sequencer.sv
// ============================================================================
// sprite_cmd_sequencer
//
// Purpose:
//   Sits between the Avalon slave port and the shared 32-bit command bus
//   that the sprite display blocks decode. Software pushes sprite command
//   words and "commit" requests into an in-order FIFO. Commands are replayed
//   one per cycle with the pp_selc bit (bit 13) steered to the back buffer.
//   Each commit turns into a single flush word (info = 4'hF) that is only
//   emitted during vertical blanking, at most once per blanking interval,
//   so buffer swaps never tear.
//
// Ports:
//   clk         in   1   system clock
//   reset       in   1   synchronous, active-high
//   chipselect  in   1   Avalon slave select
//   write       in   1   Avalon write strobe
//   read        in   1   Avalon read strobe
//   address     in   2   0 = push command, 1 = commit, 2 = status
//   writedata   in  32   Avalon write data
//   readdata    out 32   Avalon read data (registered, valid next cycle)
//   hcount      in  10   VGA horizontal count (not needed for sequencing)
//   vcount      in  10   VGA vertical count
//   cmd_out     out 32   registered command bus to the sprite blocks
//   front       out  1   buffer currently being displayed
// ============================================================================
module sprite_cmd_sequencer #(
    parameter int DEPTH        = 16,
    parameter int ADDR_W       = 4,
    parameter int VBLANK_START = 480
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        chipselect,
    input  logic        write,
    input  logic        read,
    input  logic [1:0]  address,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic [9:0]  hcount,
    input  logic [9:0]  vcount,
    output logic [31:0] cmd_out,
    output logic        front
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        WAIT_VBL = 2'd1,
        FLUSH    = 2'd2
    } stateType;

    localparam logic [ADDR_W:0] FULL_LEVEL = (ADDR_W + 1)'(DEPTH);

    stateType r_state;
    stateType w_nextState;

    // Each entry is {marker, word}; a set marker means "commit here".
    logic [32:0]       r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wrPtr;
    logic [ADDR_W-1:0] r_rdPtr;
    logic [ADDR_W:0]   r_level;
    logic              r_overflow;
    logic              r_armed;
    logic              r_prevVblank;

    logic              w_inVblank;
    logic              w_empty;
    logic              w_full;
    logic [32:0]       w_head;
    logic              w_wrReq;
    logic              w_commitReq;
    logic [32:0]       w_wrEntry;
    logic              w_push;
    logic              w_pop;
    logic              w_overflowEvent;
    logic              w_statusRead;
    logic [31:0]       w_status;
    logic [3:0]        w_levelField;
    logic [31:0]       w_nextCmd;
    logic              w_toggleFront;
    logic              w_clearArmed;
    logic              w_unused;

    // hcount is part of the shared video interface but plays no role here.
    assign w_unused = ^hcount;

    assign w_inVblank  = (vcount >= 10'(VBLANK_START));
    assign w_empty     = (r_level == '0);
    assign w_full      = (r_level == FULL_LEVEL);
    assign w_head      = r_mem[r_rdPtr];

    assign w_commitReq = chipselect & write & (address == 2'd1);
    assign w_wrReq     = (chipselect & write & (address == 2'd0)) | w_commitReq;
    assign w_wrEntry   = w_commitReq ? {1'b1, 32'h0} : {1'b0, writedata};

    // A full FIFO can still take a write when the head leaves in the same cycle.
    assign w_push          = w_wrReq & (~w_full | w_pop);
    assign w_overflowEvent = w_wrReq & ~w_push;

    assign w_statusRead = chipselect & read & (address == 2'd2);

    // The status word only has four bits for the level; a completely full
    // FIFO is identified by the full flag rather than the level field.
    assign w_levelField = 4'(r_level);
    assign w_status     = {23'b0, r_overflow, front, (r_state == WAIT_VBL),
                           w_full, w_empty, w_levelField};

    // Next-state and output decode. Commands are tagged with the back buffer
    // at pop time, so anything queued behind a commit lands on the buffer
    // that becomes the back buffer after the swap.
    always_comb begin
        w_nextState   = r_state;
        w_pop         = 1'b0;
        w_nextCmd     = 32'h0;
        w_toggleFront = 1'b0;
        w_clearArmed  = 1'b0;
        case (r_state)
            RUN: begin
                if (!w_empty) begin
                    if (w_head[32]) begin
                        w_nextState = WAIT_VBL;
                    end else begin
                        w_pop     = 1'b1;
                        w_nextCmd = {w_head[31:14], ~front, w_head[12:0]};
                    end
                end
            end
            WAIT_VBL: begin
                if (w_inVblank && r_armed) begin
                    w_pop       = 1'b1;
                    w_nextState = FLUSH;
                end
            end
            FLUSH: begin
                w_nextCmd     = {6'b0, 5'b0, 4'hF, 3'b0, ~front, 13'b0};
                w_toggleFront = 1'b1;
                w_clearArmed  = 1'b1;
                w_nextState   = RUN;
            end
            default: begin
                w_nextState = RUN;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= RUN;
        end else begin
            r_state <= w_nextState;
        end
    end

    // FIFO storage; contents need no reset because the level gates them.
    always_ff @(posedge clk) begin
        if (!reset && w_push) begin
            r_mem[r_wrPtr] <= w_wrEntry;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_level <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + ADDR_W'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + ADDR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + (ADDR_W + 1)'(1);
                2'b01:   r_level <= r_level - (ADDR_W + 1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Command bus and displayed-buffer flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_out <= 32'h0;
            front   <= 1'b0;
        end else begin
            cmd_out <= w_nextCmd;
            if (w_toggleFront) begin
                front <= ~front;
            end
        end
    end

    // The armed flag re-arms on each entry into vertical blanking so that a
    // second commit cannot swap again within the same blanking interval.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_armed      <= 1'b1;
            r_prevVblank <= 1'b0;
        end else begin
            r_prevVblank <= w_inVblank;
            if (w_clearArmed) begin
                r_armed <= 1'b0;
            end else if (w_inVblank && !r_prevVblank) begin
                r_armed <= 1'b1;
            end
        end
    end

    // Sticky overflow flag; a status read clears it, but an overflow in the
    // same cycle wins so no drop goes unreported.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= (r_overflow & ~w_statusRead) | w_overflowEvent;
        end
    end

    // Registered read port; anything other than a status read returns zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            readdata <= 32'h0;
        end else begin
            readdata <= w_statusRead ? w_status : 32'h0;
        end
    end

endmodule

// File: tb/tb_sprite_cmd_sequencer.sv
// ============================================================================
// tb_sprite_cmd_sequencer
//
// Purpose:
//   Self-checking bench for sprite_cmd_sequencer. Directed scenarios cover
//   reset, single-command latency, commit/flush ordering, the one-flush-per-
//   blanking rule, overflow and reset while waiting. A randomized run checks
//   the emitted command stream against a transaction-level model built from
//   the pushed entries.
// ============================================================================
module tb_sprite_cmd_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        chipselect;
    logic        write;
    logic        read;
    logic [1:0]  address;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [9:0]  hcount;
    logic [9:0]  vcount;
    logic [31:0] cmd_out;
    logic        front;

    int compared   = 0;
    int mismatched = 0;

    // Every non-idle word seen on the command bus, in order.
    logic [31:0] seen[$];

    always #5 clk = ~clk;

    sprite_cmd_sequencer #(
        .DEPTH(16),
        .ADDR_W(4),
        .VBLANK_START(480)
    ) dut (
        .clk(clk),
        .reset(reset),
        .chipselect(chipselect),
        .write(write),
        .read(read),
        .address(address),
        .writedata(writedata),
        .readdata(readdata),
        .hcount(hcount),
        .vcount(vcount),
        .cmd_out(cmd_out),
        .front(front)
    );

    // Expected bus word for a queued command while 'f' is the front buffer.
    function automatic logic [31:0] tagWord(input logic [31:0] w, input logic f);
        logic [31:0] r;
        r     = w;
        r[13] = ~f;
        return r;
    endfunction

    // Expected flush word while 'f' is the front buffer.
    function automatic logic [31:0] flushWord(input logic f);
        logic [31:0] r;
        r     = 32'h0;
        r[20:17] = 4'hF;
        r[13] = ~f;
        return r;
    endfunction

    // Random command word whose info field is never idle (0) or flush (F).
    function automatic logic [31:0] randWord();
        logic [31:0] w;
        w        = $urandom;
        w[20:17] = 4'($urandom_range(1, 14));
        return w;
    endfunction

    // One clock: advance past the edge, then log any non-idle command.
    task automatic tick();
        @(posedge clk);
        #1;
        if (cmd_out != 32'h0) seen.push_back(cmd_out);
    endtask

    task automatic idleBus();
        chipselect = 1'b0;
        write      = 1'b0;
        read       = 1'b0;
        address    = 2'd0;
        writedata  = 32'h0;
    endtask

    task automatic applyStimulus(input logic [1:0] addr, input logic [31:0] data);
        chipselect = 1'b1;
        write      = 1'b1;
        address    = addr;
        writedata  = data;
        tick();
        idleBus();
    endtask

    task automatic doPush(input logic [31:0] w);
        applyStimulus(2'd0, w);
    endtask

    task automatic doCommit();
        applyStimulus(2'd1, $urandom);
    endtask

    task automatic doRead(input logic [1:0] addr, output logic [31:0] v);
        chipselect = 1'b1;
        read       = 1'b1;
        address    = addr;
        tick();
        v = readdata;
        idleBus();
    endtask

    task automatic applyReset();
        idleBus();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic waitCycles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Reset values and the empty status word.
    task automatic test_reset();
        logic [31:0] v;
        vcount = 10'd100;
        applyReset();
        compared++;
        if (cmd_out !== 32'h0) begin
            mismatched++;
            $display("[TB] FAIL reset_cmd_out: got %h expected %h", cmd_out, 32'h0);
        end
        compared++;
        if (front !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_front: got %b expected %b", front, 1'b0);
        end
        compared++;
        if (readdata !== 32'h0) begin
            mismatched++;
            $display("[TB] FAIL reset_readdata: got %h expected %h", readdata, 32'h0);
        end
        doRead(2'd2, v);
        compared++;
        if (v !== 32'h0000_0010) begin
            mismatched++;
            $display("[TB] FAIL reset_status: got %h expected %h", v, 32'h10);
        end
    endtask

    // One command: appears one cycle after its pop, held for one cycle.
    task automatic test_single_push();
        vcount = 10'd100;
        applyReset();
        doPush(32'h1402_0000);
        compared++;
        if (cmd_out !== 32'h0) begin
            mismatched++;
            $display("[TB] FAIL single_before: got %h expected %h", cmd_out, 32'h0);
        end
        tick();
        compared++;
        if (cmd_out !== 32'h1402_2000) begin
            mismatched++;
            $display("[TB] FAIL single_word: got %h expected %h", cmd_out, 32'h14022000);
        end
        tick();
        compared++;
        if (cmd_out !== 32'h0) begin
            mismatched++;
            $display("[TB] FAIL single_after: got %h expected %h", cmd_out, 32'h0);
        end
    endtask

    // A, B, commit, C: flush waits for blanking and C targets the new back buffer.
    task automatic test_commit_sequence();
        logic [31:0] a, b, c;
        logic [31:0] expQ[$];
        logic [31:0] got;
        a = randWord();
        b = randWord();
        c = randWord();
        vcount = 10'd100;
        applyReset();
        seen.delete();
        doPush(a);
        doPush(b);
        doCommit();
        doPush(c);
        waitCycles(10);
        expQ = '{tagWord(a, 1'b0), tagWord(b, 1'b0)};
        compared++;
        if (seen.size() !== 2) begin
            mismatched++;
            $display("[TB] FAIL commit_pre_count: got %0d expected %0d", seen.size(), 2);
        end
        vcount = 10'd480;
        waitCycles(10);
        expQ.push_back(flushWord(1'b0));
        expQ.push_back(tagWord(c, 1'b1));
        for (int i = 0; i < expQ.size(); i++) begin
            got = (i < seen.size()) ? seen[i] : 32'hDEAD_BEEF;
            compared++;
            if (got !== expQ[i]) begin
                mismatched++;
                $display("[TB] FAIL commit_word%0d: got %h expected %h", i, got, expQ[i]);
            end
        end
        compared++;
        if (seen.size() !== expQ.size()) begin
            mismatched++;
            $display("[TB] FAIL commit_count: got %0d expected %0d", seen.size(), expQ.size());
        end
        compared++;
        if (front !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL commit_front: got %b expected %b", front, 1'b1);
        end
    endtask

    // Two commits inside one blanking interval: the second waits a frame.
    task automatic test_back_to_back_commit();
        logic [31:0] got;
        vcount = 10'd480;
        applyReset();
        seen.delete();
        doCommit();
        doCommit();
        waitCycles(8);
        got = (seen.size() > 0) ? seen[0] : 32'hDEAD_BEEF;
        compared++;
        if (got !== flushWord(1'b0)) begin
            mismatched++;
            $display("[TB] FAIL b2b_first: got %h expected %h", got, flushWord(1'b0));
        end
        compared++;
        if (seen.size() !== 1) begin
            mismatched++;
            $display("[TB] FAIL b2b_once: got %0d expected %0d", seen.size(), 1);
        end
        compared++;
        if (front !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL b2b_front1: got %b expected %b", front, 1'b1);
        end
        vcount = 10'd100;
        waitCycles(5);
        compared++;
        if (seen.size() !== 1) begin
            mismatched++;
            $display("[TB] FAIL b2b_hold: got %0d expected %0d", seen.size(), 1);
        end
        vcount = 10'd480;
        waitCycles(8);
        got = (seen.size() > 1) ? seen[1] : 32'hDEAD_BEEF;
        compared++;
        if (got !== flushWord(1'b1)) begin
            mismatched++;
            $display("[TB] FAIL b2b_second: got %h expected %h", got, flushWord(1'b1));
        end
        compared++;
        if (front !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL b2b_front0: got %b expected %b", front, 1'b0);
        end
    endtask

    // Fill behind a blocked marker, overflow, status clear and drain order.
    task automatic test_overflow();
        logic [31:0] words[$];
        logic [31:0] v;
        logic [31:0] got;
        logic [31:0] expQ[$];
        vcount = 10'd100;
        applyReset();
        doCommit();
        for (int i = 0; i < 16; i++) begin
            words.push_back(randWord());
            doPush(words[i]);
        end
        doRead(2'd2, v);
        compared++;
        if (v !== 32'h0000_0160) begin
            mismatched++;
            $display("[TB] FAIL ovf_status1: got %h expected %h", v, 32'h160);
        end
        tick();
        compared++;
        if (readdata !== 32'h0) begin
            mismatched++;
            $display("[TB] FAIL ovf_idle_read: got %h expected %h", readdata, 32'h0);
        end
        doRead(2'd2, v);
        compared++;
        if (v !== 32'h0000_0060) begin
            mismatched++;
            $display("[TB] FAIL ovf_status2: got %h expected %h", v, 32'h60);
        end
        doRead(2'd3, v);
        compared++;
        if (v !== 32'h0) begin
            mismatched++;
            $display("[TB] FAIL ovf_addr3: got %h expected %h", v, 32'h0);
        end
        seen.delete();
        vcount = 10'd480;
        waitCycles(25);
        expQ.push_back(flushWord(1'b0));
        for (int i = 0; i < 15; i++) expQ.push_back(tagWord(words[i], 1'b1));
        for (int i = 0; i < expQ.size(); i++) begin
            got = (i < seen.size()) ? seen[i] : 32'hDEAD_BEEF;
            compared++;
            if (got !== expQ[i]) begin
                mismatched++;
                $display("[TB] FAIL ovf_drain%0d: got %h expected %h", i, got, expQ[i]);
            end
        end
        compared++;
        if (seen.size() !== expQ.size()) begin
            mismatched++;
            $display("[TB] FAIL ovf_drain_count: got %0d expected %0d", seen.size(), expQ.size());
        end
    endtask

    // Reset while waiting for blanking discards the queue and the pending swap.
    task automatic test_reset_in_wait();
        logic [31:0] v;
        vcount = 10'd480;
        applyReset();
        doCommit();
        waitCycles(5);
        vcount = 10'd100;
        waitCycles(3);
        doCommit();
        doPush(randWord());
        doPush(randWord());
        waitCycles(3);
        doRead(2'd2, v);
        compared++;
        if (v !== 32'h0000_00C3) begin
            mismatched++;
            $display("[TB] FAIL rstw_status_wait: got %h expected %h", v, 32'hC3);
        end
        reset = 1'b1;
        tick();
        compared++;
        if (cmd_out !== 32'h0) begin
            mismatched++;
            $display("[TB] FAIL rstw_cmd_out: got %h expected %h", cmd_out, 32'h0);
        end
        compared++;
        if (front !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL rstw_front: got %b expected %b", front, 1'b0);
        end
        reset = 1'b0;
        doRead(2'd2, v);
        compared++;
        if (v !== 32'h0000_0010) begin
            mismatched++;
            $display("[TB] FAIL rstw_status_empty: got %h expected %h", v, 32'h10);
        end
        seen.delete();
        vcount = 10'd480;
        waitCycles(10);
        compared++;
        if (seen.size() !== 0) begin
            mismatched++;
            $display("[TB] FAIL rstw_no_flush: got %0d expected %0d", seen.size(), 0);
        end
        compared++;
        if (front !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL rstw_front_after: got %b expected %b", front, 1'b0);
        end
    endtask

    // Random pushes/commits against a scrolling vcount. The model replays the
    // pushed entries in order, toggling its own front on every commit, and
    // checks each flush came from a blanking line in a newer frame.
    task automatic test_random();
        logic [32:0] pushedQ[$];
        logic [31:0] expQ[$];
        logic [31:0] got;
        logic        runFront;
        logic        f;
        int          emitted;
        int          frame;
        int          prevFrame;
        int          lastFlushFrame;
        int          prevVcount;
        int          r;
        vcount = 10'd440;
        applyReset();
        seen.delete();
        runFront       = 1'b0;
        emitted        = 0;
        frame          = 0;
        prevFrame      = 0;
        lastFlushFrame = -1;
        prevVcount     = 440;
        for (int cnt = 1; cnt <= 2400; cnt++) begin
            vcount = 10'(440 + (cnt % 60));
            if (vcount == 10'd480) frame++;
            idleBus();
            if (cnt < 1500 && (pushedQ.size() - emitted) < 12) begin
                r = $urandom_range(0, 99);
                if (r < 30) begin
                    chipselect = 1'b1;
                    write      = 1'b1;
                    address    = 2'd0;
                    writedata  = randWord();
                    pushedQ.push_back({1'b0, writedata});
                end else if (r < 34) begin
                    chipselect = 1'b1;
                    write      = 1'b1;
                    address    = 2'd1;
                    writedata  = $urandom;
                    pushedQ.push_back({1'b1, 32'h0});
                end
            end
            tick();
            if (cmd_out != 32'h0) begin
                emitted++;
                if (cmd_out[20:17] == 4'hF) begin
                    runFront = ~runFront;
                    compared++;
                    if (prevVcount < 480) begin
                        mismatched++;
                        $display("[TB] FAIL rand_flush_vblank: got vcount %0d expected >= %0d", prevVcount, 480);
                    end
                    compared++;
                    if (prevFrame <= lastFlushFrame) begin
                        mismatched++;
                        $display("[TB] FAIL rand_flush_frame: got frame %0d expected > %0d", prevFrame, lastFlushFrame);
                    end
                    lastFlushFrame = prevFrame;
                end
            end
            compared++;
            if (front !== runFront) begin
                mismatched++;
                $display("[TB] FAIL rand_front: got %b expected %b at cycle %0d", front, runFront, cnt);
            end
            prevVcount = int'(vcount);
            prevFrame  = frame;
        end
        idleBus();
        f = 1'b0;
        foreach (pushedQ[i]) begin
            if (pushedQ[i][32]) begin
                expQ.push_back(flushWord(f));
                f = ~f;
            end else begin
                expQ.push_back(tagWord(pushedQ[i][31:0], f));
            end
        end
        compared++;
        if (seen.size() !== expQ.size()) begin
            mismatched++;
            $display("[TB] FAIL rand_count: got %0d expected %0d", seen.size(), expQ.size());
        end
        for (int i = 0; i < expQ.size(); i++) begin
            got = (i < seen.size()) ? seen[i] : 32'hDEAD_BEEF;
            compared++;
            if (got !== expQ[i]) begin
                mismatched++;
                $display("[TB] FAIL rand_word%0d: got %h expected %h", i, got, expQ[i]);
            end
        end
    endtask

    initial begin
        reset  = 1'b1;
        hcount = 10'd0;
        vcount = 10'd100;
        idleBus();
        test_reset();
        test_single_push();
        test_commit_sequence();
        test_back_to_back_commit();
        test_overflow();
        test_reset_in_wait();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
